// File: rtl/inst_rom_ctrl_pkg.sv
// Shared types and constants for the instruction-memory controller.
package inst_rom_ctrl_pkg;

    typedef logic [31:0] InstBus;
    typedef logic [31:0] InstAddrBus;

    localparam InstBus ZeroWord  = 32'h0000_0000;
    localparam logic   RstEnable = 1'b0;

    typedef enum logic [1:0] {
        RomIdle = 2'b00,
        RomLoad = 2'b01,
        RomRun  = 2'b10
    } rom_state_e;

endpackage

// File: rtl/inst_ram.sv
// Word-addressed instruction storage: one synchronous write port, one
// asynchronous read port. Contents are never reset.
module inst_ram
    import inst_rom_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  InstBus                wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output InstBus                rdata_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    InstBus mem [Depth];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/inst_rom_ctrl.sv
// Instruction-memory controller: loads a program image over a valid/ready
// stream while holding the core in reset, then serves combinational fetches.
module inst_rom_ctrl
    import inst_rom_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_start,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  InstBus              ld_data,
    input  logic                ld_last,
    output logic [DEPTH_LOG2:0] ld_count,
    output logic                ld_done,
    output logic                ld_err,
    output logic                core_rst,
    input  logic                rom_en,
    input  InstAddrBus          rom_addr,
    output InstBus              rom_data
);

    rom_state_e          state_q, state_d;
    logic [DEPTH_LOG2:0] count_q, count_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic                core_rst_q, core_rst_d;
    logic                ram_we;
    logic                addr_in_range;
    InstBus              ram_rdata;
    logic                unused_addr;

    // The count doubles as the write pointer; its top bit flags a full RAM.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        ram_we  = 1'b0;
        unique case (state_q)
            RomIdle: begin
                if (ld_start) begin
                    state_d = RomLoad;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            RomLoad: begin
                if (ld_start) begin
                    // Restart wins; a transfer in this cycle is discarded.
                    count_d = '0;
                    err_d   = 1'b0;
                end else if (ld_valid) begin
                    if (!count_q[DEPTH_LOG2]) begin
                        ram_we  = 1'b1;
                        count_d = count_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
                    end else begin
                        err_d = 1'b1;
                    end
                    if (ld_last) begin
                        state_d = RomRun;
                    end
                end
            end
            RomRun: begin
                if (ld_start) begin
                    state_d = RomLoad;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = RomIdle;
            end
        endcase

        ready_d    = (state_d == RomLoad);
        done_d     = (state_d == RomRun);
        core_rst_d = (state_d == RomRun) ? ~RstEnable : RstEnable;
    end

    // State, pointer and registered status outputs
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q    <= RomIdle;
            count_q    <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            core_rst_q <= RstEnable;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            core_rst_q <= core_rst_d;
        end
    end

    inst_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_inst_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (count_q[DEPTH_LOG2-1:0]),
        .wdata_i (ld_data),
        .raddr_i (rom_addr[DEPTH_LOG2+1:2]),
        .rdata_o (ram_rdata)
    );

    assign addr_in_range = (rom_addr[31:DEPTH_LOG2+2] == '0);
    assign unused_addr   = ^rom_addr[1:0];

    // Fetch gating: anything outside RUN, disabled or out of range reads as NOP
    always_comb begin
        rom_data = ZeroWord;
        if ((state_q == RomRun) && rom_en && addr_in_range) begin
            rom_data = ram_rdata;
        end
    end

    assign ld_ready = ready_q;
    assign ld_done  = done_q;
    assign ld_err   = err_q;
    assign core_rst = core_rst_q;
    assign ld_count = count_q;

endmodule
